// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
// State encoding and default sizing.
package fifo_arb_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam int NREQ_DEF  = 4;
    localparam int DW_DEF    = 8;
    localparam int BURST_DEF = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin priority encoder.
// Searches last+1, last+2, ... (mod NREQ) for the first request.
import fifo_arb_pkg::*;

module rr_pick #(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] pick,
    output logic [IW-1:0]   idx
);

    logic          found;
    logic [IW-1:0] j;

    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int i = 1; i <= NREQ; i++) begin
            j = IW'((int'(last) + i) % NREQ);
            if (!found && req[j]) begin
                found   = 1'b1;
                pick[j] = 1'b1;
                idx     = j;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between NREQ producers.
// Each grant lasts at most BURST accepted words; fifo_full stalls in place.
import fifo_arb_pkg::*;

module fifo_wr_arbiter #(
    parameter int NREQ  = NREQ_DEF,
    parameter int DW    = DW_DEF,
    parameter int BURST = BURST_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic             fifo_full,
    output logic [NREQ-1:0]    ack,
    output logic [NREQ-1:0]    grant,
    output logic             fifo_wr_en,
    output logic [DW-1:0]      fifo_data_in,
    output logic             busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(BURST + 1);

    logic [0:0]      state;
    logic [IW-1:0]   last;
    logic [IW-1:0]   owner;
    logic [CW-1:0]   cnt;
    logic [NREQ-1:0] pick;
    logic [IW-1:0]   pick_idx;
    logic            accept;
    logic            last_word;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req  (req),
        .last (last),
        .pick (pick),
        .idx  (pick_idx)
    );

    assign busy       = (state == ST_GRANT);
    assign accept     = busy & req[owner] & ~fifo_full;
    assign last_word  = (cnt == CW'(BURST - 1));
    assign fifo_wr_en = accept;
    assign ack        = accept ? grant : '0;

    // grant is one-hot, so an OR of masked lanes is the data mux
    always_comb begin
        fifo_data_in = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) fifo_data_in = fifo_data_in | req_data[i*DW +: DW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            grant <= '0;
            last  <= IW'(NREQ - 1);
            owner <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        state <= ST_GRANT;
                        grant <= pick;
                        owner <= pick_idx;
                        cnt   <= '0;
                    end
                end
                ST_GRANT: begin
                    if (!req[owner] || (accept && last_word)) begin
                        state <= ST_IDLE;
                        grant <= '0;
                        last  <= owner;
                    end else if (accept) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter.
// Inputs driven 1 time unit after the rising edge, outputs checked 1 unit later.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        fifo_full;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        fifo_wr_en;
    logic [7:0]  fifo_data_in;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    fifo_wr_arbiter #(.NREQ(4), .DW(8), .BURST(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .fifo_full    (fifo_full),
        .ack          (ack),
        .grant        (grant),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g,
                           input logic we, input logic [7:0] d);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".wr_en"}, 32'(fifo_wr_en), 32'(we));
        chk({tag, ".ack"}, 32'(ack), we ? 32'(g) : 32'd0);
        chk({tag, ".data"}, 32'(fifo_data_in), 32'(d));
        chk({tag, ".busy"}, 32'(busy), 32'(g != 4'd0));
    endtask

    function automatic logic [7:0] byte_of(input logic [3:0] g);
        case (g)
            4'b0001: byte_of = 8'hA5;
            4'b0010: byte_of = 8'h22;
            4'b0100: byte_of = 8'h33;
            4'b1000: byte_of = 8'h44;
            default: byte_of = 8'h00;
        endcase
    endfunction

    initial begin
        logic [3:0] eg;
        int         writes;

        rst       = 1'b1;
        req       = '0;
        req_data  = {8'h44, 8'h33, 8'h22, 8'hA5};
        fifo_full = 1'b0;

        // reset state and first grant
        cyc(); #1;
        chk_out("reset", 4'b0000, 1'b0, 8'h00);
        rst = 1'b0;
        cyc(); req = 4'b0001; #1;
        chk_out("first_idle", 4'b0000, 1'b0, 8'h00);
        cyc(); #1;
        chk_out("first_grant", 4'b0001, 1'b1, 8'hA5);
        cyc(); req = 4'b0000; #1;
        cyc(); #1;
        chk_out("first_done", 4'b0000, 1'b0, 8'h00);

        // round-robin from reset: owners 0,1,2,3,0
        rst = 1'b1; #1; rst = 1'b0;
        cyc(); req = 4'b1111; #1;
        writes = 0;
        for (int k = 0; k < 22; k++) begin
            if (k > 0) cyc();
            #1;
            eg = (k % 5 == 0) ? 4'b0000 : 4'(1 << ((k / 5) % 4));
            chk_out($sformatf("rr%0d", k), eg, eg != 4'd0, byte_of(eg));
            if (k < 20 && fifo_wr_en) writes++;
        end
        chk("rr_writes", 32'(writes), 32'd16);
        cyc(); req = 4'b0000; #1;
        chk_out("rr_drop", 4'b0001, 1'b0, 8'hA5);
        cyc(); #1;
        chk_out("rr_idle", 4'b0000, 1'b0, 8'h00);

        // full stall on owner 1
        cyc(); req = 4'b0010; #1;
        chk_out("st_idle", 4'b0000, 1'b0, 8'h00);
        cyc(); #1; chk_out("st_w1", 4'b0010, 1'b1, 8'h22);
        cyc(); #1; chk_out("st_w2", 4'b0010, 1'b1, 8'h22);
        for (int k = 0; k < 3; k++) begin
            cyc(); fifo_full = 1'b1; #1;
            chk_out($sformatf("st_full%0d", k), 4'b0010, 1'b0, 8'h22);
        end
        cyc(); fifo_full = 1'b0; #1;
        chk_out("st_w3", 4'b0010, 1'b1, 8'h22);
        cyc(); #1; chk_out("st_w4", 4'b0010, 1'b1, 8'h22);
        cyc(); req = 4'b0000; #1;
        chk_out("st_end", 4'b0000, 1'b0, 8'h00);

        // early release by owner 2, requester 3 waiting
        cyc(); req = 4'b1100; #1;
        chk_out("er_idle", 4'b0000, 1'b0, 8'h00);
        cyc(); #1; chk_out("er_w1", 4'b0100, 1'b1, 8'h33);
        cyc(); #1; chk_out("er_w2", 4'b0100, 1'b1, 8'h33);
        cyc(); req = 4'b1000; #1;
        chk_out("er_drop", 4'b0100, 1'b0, 8'h33);
        cyc(); #1; chk_out("er_gap", 4'b0000, 1'b0, 8'h00);
        cyc(); #1; chk_out("er_g3", 4'b1000, 1'b1, 8'h44);
        cyc(); #1; chk_out("er_g3w2", 4'b1000, 1'b1, 8'h44);

        // async reset between edges during owner 3 burst
        #1 rst = 1'b1;
        #1;
        chk_out("ar_now", 4'b0000, 1'b0, 8'h00);
        #1 rst = 1'b0;
        req = 4'b1001;
        cyc(); #1;
        chk_out("ar_g0", 4'b0001, 1'b1, 8'hA5);
        cyc(); req = 4'b0000; #1;
        cyc(); #1;
        chk_out("ar_idle", 4'b0000, 1'b0, 8'h00);

        // early release by owner 2 with requester 0 waiting
        rst = 1'b1; #1; rst = 1'b0;
        req = 4'b0100;
        cyc(); #1; chk_out("e0_w1", 4'b0100, 1'b1, 8'h33);
        cyc(); #1; chk_out("e0_w2", 4'b0100, 1'b1, 8'h33);
        cyc(); req = 4'b0001; #1;
        chk_out("e0_drop", 4'b0100, 1'b0, 8'h33);
        cyc(); #1; chk_out("e0_gap", 4'b0000, 1'b0, 8'h00);
        cyc(); #1; chk_out("e0_g0", 4'b0001, 1'b1, 8'hA5);
        cyc(); req = 4'b0000; #1;
        cyc(); #1;
        chk_out("e0_idle", 4'b0000, 1'b0, 8'h00);

        // lone requester 3 for 10 words: bursts 4,4,2
        writes = 0;
        for (int k = 0; k < 15; k++) begin
            cyc();
            req = (k < 13) ? 4'b1000 : 4'b0000;
            #1;
            eg = ((k >= 1 && k <= 4) || (k >= 6 && k <= 9) ||
                  (k >= 11 && k <= 13)) ? 4'b1000 : 4'b0000;
            chk_out($sformatf("lone%0d", k), eg,
                    (eg != 4'd0) && (k != 13), byte_of(eg));
            if (fifo_wr_en) writes++;
        end
        chk("lone_writes", 32'(writes), 32'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
